// File: rtl/uart_rx_frame_param.sv
// Parametrised command-frame UART receiver: start, RW, address, data, optional parity, 1-2 stop bits.
// Majority-vote bit sampling with false-start rejection; one-entry valid/ready output buffer with sticky overrun.
module uart_rx_frame_param #(
    parameter int CLK_DIV     = 104,
    parameter int OVERSAMPLE  = 16,
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 4,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              frame_ready,
    input  logic              ovr_clr,
    output logic              frame_valid,
    output logic              rw_bit,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int SMP_W = $clog2(OVERSAMPLE);
    localparam int FLD_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = 5;

    localparam logic [SMP_W-1:0] SMP_A   = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_B   = SMP_W'(OVERSAMPLE / 2);
    localparam logic [SMP_W-1:0] SMP_C   = SMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SMP_W-1:0] SMP_END = SMP_W'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_RW        = 3'd2;
    localparam logic [2:0] S_ADDR      = 3'd3;
    localparam logic [2:0] S_DATA      = 3'd4;
    localparam logic [2:0] S_PARITY    = 3'd5;
    localparam logic [2:0] S_STOP      = 3'd6;
    localparam logic [2:0] S_WAIT_IDLE = 3'd7;

    logic              r_rx_meta;
    logic              r_rx_s;
    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [SMP_W-1:0]  r_smp_cnt;
    logic [1:0]        r_smp;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [FLD_W-1:0]  r_shift;
    logic              r_par_bit;
    logic              r_ferr;

    logic              r_valid;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_perr;
    logic              r_ferr_out;
    logic              r_ovr;

    logic w_start;
    logic w_tick;
    logic w_resolve;
    logic w_bit_end;
    logic w_maj;
    logic w_last_stop;
    logic w_complete;
    logic w_ferr_now;
    logic w_par_exp;
    logic w_perr;
    logic w_load;

    assign w_start     = (r_state == S_IDLE) && !r_rx_s;
    assign w_tick      = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_resolve   = w_tick && (r_smp_cnt == SMP_C);
    assign w_bit_end   = w_tick && (r_smp_cnt == SMP_END);
    // Third sample is the live synchronised line, taken in the resolve cycle itself.
    assign w_maj       = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_rx_s) | (r_smp[0] & r_rx_s);
    assign w_last_stop = (r_state == S_STOP) && (r_bit_cnt == CNT_W'(STOP_BITS - 1));
    assign w_complete  = w_resolve && w_last_stop;
    assign w_ferr_now  = r_ferr | ~w_maj;
    assign w_par_exp   = (^r_shift) ^ (PARITY_MODE == 2);
    assign w_perr      = (PARITY_MODE != 0) && (r_par_bit != w_par_exp);
    assign w_load      = w_complete && (!r_valid || frame_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_div_cnt <= '0;
            r_smp_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_smp_cnt <= (r_smp_cnt == SMP_END) ? '0 : r_smp_cnt + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp <= 2'b11;
        end else if (w_tick && (r_smp_cnt == SMP_A)) begin
            r_smp[1] <= r_rx_s;
        end else if (w_tick && (r_smp_cnt == SMP_B)) begin
            r_smp[0] <= r_rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_ferr  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_resolve && w_maj) r_state <= S_IDLE;
                    else if (w_bit_end)     r_state <= S_RW;
                end
                S_RW: begin
                    if (w_resolve) r_shift <= {r_shift[FLD_W-2:0], w_maj};
                    if (w_bit_end) begin
                        r_state   <= S_ADDR;
                        r_bit_cnt <= '0;
                    end
                end
                S_ADDR: begin
                    if (w_resolve) r_shift <= {r_shift[FLD_W-2:0], w_maj};
                    if (w_bit_end) begin
                        if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_resolve) r_shift <= {r_shift[FLD_W-2:0], w_maj};
                    if (w_bit_end) begin
                        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                            r_state   <= (PARITY_MODE == 0) ? S_STOP : S_PARITY;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_resolve) r_par_bit <= w_maj;
                    if (w_bit_end) begin
                        r_state   <= S_STOP;
                        r_bit_cnt <= '0;
                    end
                end
                S_STOP: begin
                    // Leave at the last stop mid-sample so a following start edge is not missed.
                    if (w_resolve) begin
                        r_ferr <= w_ferr_now;
                        if (w_last_stop) r_state <= w_ferr_now ? S_WAIT_IDLE : S_IDLE;
                    end else if (w_bit_end) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_ferr_out <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_rw       <= r_shift[FLD_W-1];
                r_addr     <= r_shift[DATA_W +: ADDR_W];
                r_data     <= r_shift[DATA_W-1:0];
                r_perr     <= w_perr;
                r_ferr_out <= w_ferr_now;
            end else if (r_valid && frame_ready) begin
                r_valid <= 1'b0;
            end
            // A new drop wins over a simultaneous clear.
            if (w_complete && r_valid && !frame_ready) r_ovr <= 1'b1;
            else if (ovr_clr)                          r_ovr <= 1'b0;
        end
    end

    assign frame_valid = r_valid;
    assign rw_bit      = r_rw;
    assign addr        = r_addr;
    assign data        = r_data;
    assign parity_err  = r_perr;
    assign frame_err   = r_ferr_out;
    assign overrun     = r_ovr;
    assign busy        = (r_state != S_IDLE);

endmodule
